// File: rtl/vs1003_pkg.sv
// VS1003 SCI constants shared by the register reader and the existing writer.
package vs1003_pkg;

    localparam logic [7:0] SCI_READ  = 8'h03;
    localparam logic [7:0] SCI_WRITE = 8'h02;

    localparam logic [3:0] REG_MODE        = 4'h0;
    localparam logic [3:0] REG_STATUS      = 4'h1;
    localparam logic [3:0] REG_DECODE_TIME = 4'h4;
    localparam logic [3:0] REG_HDAT0       = 4'h8;
    localparam logic [3:0] REG_HDAT1       = 4'h9;
    localparam logic [3:0] REG_VOL         = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DREQ,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } sci_rd_state_e;

    // Full 32-bit read frame: opcode, zero-extended address, 16 dummy bits.
    function automatic logic [31:0] sci_read_frame(input logic [3:0] addr);
        return {SCI_READ, 4'h0, addr, 16'h0000};
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// SCLK phase/bit sequencer for 32-bit SCI frames: SCLK plus strobes flagging
// the edge that starts a LOW phase, the edge that raises SCLK, and the frame end.
module spi_bit_timer #(
    parameter int SCLK_HALF = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_en,
    output logic       o_sclk,
    output logic       o_low_stb,
    output logic       o_sample_stb,
    output logic       o_last,
    output logic [4:0] o_bit
);

    localparam int            CW     = $clog2(SCLK_HALF) + 1;
    localparam logic [CW-1:0] PH_MAX = CW'(SCLK_HALF - 1);

    logic [CW-1:0] r_ph;
    logic [4:0]    r_bit;
    logic          r_sclk;
    logic          w_ph_end;

    assign w_ph_end = (r_ph == PH_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load || !i_en) begin
            r_ph   <= '0;
            r_bit  <= '0;
            r_sclk <= 1'b0;
        end else if (w_ph_end) begin
            r_ph   <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
                r_bit <= r_bit + 5'd1;
            end
        end else begin
            r_ph <= r_ph + CW'(1);
        end
    end

    // Strobes are asserted in the cycle before the edge they describe.
    assign o_low_stb    = i_load | (i_en & w_ph_end & r_sclk & (r_bit != 5'd31));
    assign o_sample_stb = i_en & w_ph_end & ~r_sclk;
    assign o_last       = i_en & w_ph_end & r_sclk & (r_bit == 5'd31);
    assign o_sclk       = r_sclk;
    assign o_bit        = r_bit;

endmodule

// File: rtl/vs1003_sci_reader.sv
// SPI master reading one 16-bit VS1003 SCI register; waits for DREQ, shifts a
// 32-bit read frame, captures the data half from MISO and pulses done.
module vs1003_sci_reader
    import vs1003_pkg::*;
#(
    parameter int SCLK_HALF = 1,
    parameter int CS_HOLD   = 2
) (
    input  logic        mp3_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  reg_addr,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    input  logic        DREQ,
    input  logic        MISO,
    output logic        CS,
    output logic        SCLK,
    output logic        MOSI
);

    localparam int            HW        = $clog2(CS_HOLD + 1) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);

    sci_rd_state_e r_state;
    sci_rd_state_e w_next;

    logic [31:0]   r_shift;
    logic [15:0]   r_cap;
    logic [15:0]   r_rdata;
    logic          r_mosi;
    logic [HW-1:0] r_hold;

    logic          w_load;
    logic          w_en;
    logic          w_low_stb;
    logic          w_sample_stb;
    logic          w_last;
    logic          w_hold_end;
    logic [4:0]    w_bit;
    logic          w_cs;
    logic          w_busy;
    logic          w_done;

    assign w_load     = (r_state == SETUP);
    assign w_en       = (r_state == SHIFT);
    assign w_hold_end = (r_hold >= HOLD_LAST);

    spi_bit_timer #(
        .SCLK_HALF(SCLK_HALF)
    ) u_timer (
        .i_clk       (mp3_clk),
        .i_rst       (rst),
        .i_load      (w_load),
        .i_en        (w_en),
        .o_sclk      (SCLK),
        .o_low_stb   (w_low_stb),
        .o_sample_stb(w_sample_stb),
        .o_last      (w_last),
        .o_bit       (w_bit)
    );

    always_ff @(posedge mp3_clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cs   = 1'b1;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = WAIT_DREQ;
                end
            end
            WAIT_DREQ: begin
                w_busy = 1'b1;
                if (DREQ) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_busy = 1'b1;
                w_cs   = 1'b0;
                w_next = SHIFT;
            end
            SHIFT: begin
                w_busy = 1'b1;
                w_cs   = 1'b0;
                if (w_last) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                w_busy = 1'b1;
                if (w_hold_end) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Zeros shift in behind the address, so MOSI is low for the data half.
    always_ff @(posedge mp3_clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cap   <= '0;
            r_mosi  <= 1'b0;
            r_rdata <= '0;
            r_hold  <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_shift <= sci_read_frame(reg_addr);
            end else if (w_low_stb) begin
                r_shift <= {r_shift[30:0], 1'b0};
            end
            if (w_low_stb) begin
                r_mosi <= r_shift[31];
            end else if (w_last) begin
                r_mosi <= 1'b0;
            end
            if (w_sample_stb && w_bit[4]) begin
                r_cap <= {r_cap[14:0], MISO};
            end
            r_hold <= (r_state == HOLD) ? r_hold + HW'(1) : '0;
            if (r_state == HOLD && w_hold_end) begin
                r_rdata <= r_cap;
            end
        end
    end

    assign CS    = w_cs;
    assign busy  = w_busy;
    assign done  = w_done;
    assign rdata = r_rdata;
    assign MOSI  = r_mosi;

endmodule

// File: tb/tb_vs1003_sci_reader.sv
// Bench for vs1003_sci_reader: two instances (SCLK_HALF 1 and 2) driven by a
// behavioural VS1003 slave, with latencies and frames predicted from the SCI rules.
module tb_vs1003_sci_reader;
    import vs1003_pkg::*;

    localparam int HOLD_CYC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        DREQ = 1'b0;
    logic [3:0]  reg_addr = 4'h0;
    logic        sel = 1'b0;

    logic        start_a, busy_a, done_a, cs_a, sclk_a, mosi_a, miso_a;
    logic        start_b, busy_b, done_b, cs_b, sclk_b, mosi_b, miso_b;
    logic [15:0] rdata_a, rdata_b;
    logic        m_busy, m_done, m_cs, m_sclk, m_mosi;
    logic [15:0] m_rdata;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign m_busy  = sel ? busy_b  : busy_a;
    assign m_done  = sel ? done_b  : done_a;
    assign m_cs    = sel ? cs_b    : cs_a;
    assign m_sclk  = sel ? sclk_b  : sclk_a;
    assign m_mosi  = sel ? mosi_b  : mosi_a;
    assign m_rdata = sel ? rdata_b : rdata_a;

    vs1003_sci_reader #(.SCLK_HALF(1), .CS_HOLD(HOLD_CYC)) u_dut_a (
        .mp3_clk(clk), .rst(rst), .start(start_a), .reg_addr(reg_addr),
        .busy(busy_a), .done(done_a), .rdata(rdata_a), .DREQ(DREQ),
        .MISO(miso_a), .CS(cs_a), .SCLK(sclk_a), .MOSI(mosi_a)
    );

    vs1003_sci_reader #(.SCLK_HALF(2), .CS_HOLD(HOLD_CYC)) u_dut_b (
        .mp3_clk(clk), .rst(rst), .start(start_b), .reg_addr(reg_addr),
        .busy(busy_b), .done(done_b), .rdata(rdata_b), .DREQ(DREQ),
        .MISO(miso_b), .CS(cs_b), .SCLK(sclk_b), .MOSI(mosi_b)
    );

    // Slave model: SPI mode 0, data bits presented after the 16th rise, MSB first.
    logic [15:0] slave_val = 16'h0000;
    int          rise_a = 0, rise_b = 0;
    logic [31:0] cmd_a = '0, cmd_b = '0;

    always @(negedge cs_a) begin rise_a = 0; cmd_a = '0; end
    always @(negedge cs_b) begin rise_b = 0; cmd_b = '0; end
    always @(posedge sclk_a) begin cmd_a = {cmd_a[30:0], mosi_a}; rise_a++; end
    always @(posedge sclk_b) begin cmd_b = {cmd_b[30:0], mosi_b}; rise_b++; end

    assign miso_a = (!cs_a && rise_a >= 16 && rise_a < 32) ? slave_val[4'(31 - rise_a)] : 1'b0;
    assign miso_b = (!cs_b && rise_b >= 16 && rise_b < 32) ? slave_val[4'(31 - rise_b)] : 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Observations from the last transaction, edge numbers relative to the accepting edge.
    int          obs_done_edge, obs_done_cnt, obs_cs_lo, obs_cs_hi, obs_rises;
    int          obs_min_iv, obs_max_iv, obs_wait_bad;
    logic        obs_busy0, obs_busy_at_done;
    logic [15:0] obs_rdata;
    logic [31:0] obs_cmd;
    logic        rs_cs, rs_sclk, rs_busy, rs_done, rs_mosi;
    logic [15:0] rs_rdata;

    function automatic int exp_latency(input int sh, input int dly);
        return 2 + 64 * sh + HOLD_CYC + dly;
    endfunction

    task automatic run_txn(input logic s, input logic [3:0] addr, input logic [15:0] val,
                           input int dly, input int inj, input int rst_at, input int max_n);
        logic p_sclk, p_cs;
        int   last_rise;
        @(negedge clk);
        sel = s; slave_val = val; reg_addr = addr; start = 1'b1; DREQ = (dly == 0);
        obs_done_edge = -1; obs_done_cnt = 0; obs_cs_lo = -1; obs_cs_hi = -1; obs_rises = 0;
        obs_min_iv = 1000000; obs_max_iv = 0; obs_wait_bad = 0; obs_busy_at_done = 1'bx;
        obs_rdata = 'x;
        @(posedge clk); #1;
        start = 1'b0;
        obs_busy0 = m_busy;
        p_sclk = m_sclk; p_cs = m_cs; last_rise = -1;
        for (int n = 1; n <= max_n; n++) begin
            if (n - 1 == dly) DREQ = 1'b1;
            start = (n == inj);
            rst = (n == rst_at);
            @(posedge clk); #1;
            if (n <= dly && (m_cs !== 1'b1 || m_sclk !== 1'b0 || m_busy !== 1'b1)) obs_wait_bad++;
            if (m_sclk === 1'b1 && p_sclk === 1'b0) begin
                obs_rises++;
                if (last_rise >= 0) begin
                    if (n - last_rise < obs_min_iv) obs_min_iv = n - last_rise;
                    if (n - last_rise > obs_max_iv) obs_max_iv = n - last_rise;
                end
                last_rise = n;
            end
            if (m_cs === 1'b0 && p_cs === 1'b1 && obs_cs_lo < 0) obs_cs_lo = n;
            if (m_cs === 1'b1 && p_cs === 1'b0 && obs_cs_hi < 0) obs_cs_hi = n;
            if (m_done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_edge < 0) begin
                    obs_done_edge = n; obs_rdata = m_rdata; obs_busy_at_done = m_busy;
                end
            end
            if (n == rst_at) begin
                rs_cs = m_cs; rs_sclk = m_sclk; rs_busy = m_busy;
                rs_done = m_done; rs_mosi = m_mosi; rs_rdata = m_rdata;
            end
            p_sclk = m_sclk; p_cs = m_cs;
            if (obs_done_edge >= 0 && n >= obs_done_edge + 1) break;
        end
        start = 1'b0; rst = 1'b0;
        obs_cmd = s ? cmd_b : cmd_a;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; DREQ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (cs_a !== 1'b1) begin n_fail++; $display("FAIL reset_cs got=%b want=1", cs_a); end
        n_chk++; if (sclk_a !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b want=0", sclk_a); end
        n_chk++; if (mosi_a !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b want=0", mosi_a); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_a); end
        n_chk++; if (rdata_a !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got=%h want=0000", rdata_a); end
        n_chk++; if (cs_b !== 1'b1 || sclk_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b cs=%b sclk=%b busy=%b want 1/0/0", cs_b, sclk_b, busy_b); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_status();
        logic [31:0] ecmd;
        ecmd = {SCI_READ, 4'h0, REG_STATUS, 16'h0000};
        run_txn(1'b0, REG_STATUS, 16'h0040, 0, -1, -1, 300);
        n_chk++; if (obs_busy0 !== 1'b1) begin n_fail++; $display("FAIL status_busy_accept got=%b want=1", obs_busy0); end
        n_chk++; if (obs_cs_lo !== 1) begin n_fail++; $display("FAIL status_cs_low_edge got=%0d want=1", obs_cs_lo); end
        n_chk++; if (obs_cmd[31:24] !== 8'h03) begin n_fail++; $display("FAIL status_opcode got=%h want=03", obs_cmd[31:24]); end
        n_chk++; if (obs_cmd[23:16] !== 8'h01) begin n_fail++; $display("FAIL status_addr got=%h want=01", obs_cmd[23:16]); end
        n_chk++; if (obs_cmd !== ecmd) begin n_fail++; $display("FAIL status_frame got=%h want=%h", obs_cmd, ecmd); end
        n_chk++; if (obs_rises !== 32) begin n_fail++; $display("FAIL status_rises got=%0d want=32", obs_rises); end
        n_chk++; if (obs_min_iv !== 2 || obs_max_iv !== 2) begin n_fail++; $display("FAIL status_period got=%0d..%0d want=2", obs_min_iv, obs_max_iv); end
        n_chk++; if (obs_cs_hi !== 66) begin n_fail++; $display("FAIL status_cs_high_edge got=%0d want=66", obs_cs_hi); end
        n_chk++; if (obs_done_edge !== exp_latency(1, 0)) begin n_fail++; $display("FAIL status_done_edge got=%0d want=%0d", obs_done_edge, exp_latency(1, 0)); end
        n_chk++; if (obs_rdata !== 16'h0040) begin n_fail++; $display("FAIL status_rdata got=%h want=0040", obs_rdata); end
        n_chk++; if (obs_busy_at_done !== 1'b0) begin n_fail++; $display("FAIL status_busy_at_done got=%b want=0", obs_busy_at_done); end
        n_chk++; if (obs_done_cnt !== 1) begin n_fail++; $display("FAIL status_done_pulses got=%0d want=1", obs_done_cnt); end
    endtask

    task automatic test_dreq_gating();
        run_txn(1'b0, REG_DECODE_TIME, 16'h1357, 10, -1, -1, 300);
        n_chk++; if (obs_wait_bad !== 0) begin n_fail++; $display("FAIL dreq_wait_outputs bad_cycles=%0d want=0", obs_wait_bad); end
        n_chk++; if (obs_busy0 !== 1'b1) begin n_fail++; $display("FAIL dreq_busy got=%b want=1", obs_busy0); end
        n_chk++; if (obs_cs_lo !== 11) begin n_fail++; $display("FAIL dreq_cs_low_edge got=%0d want=11", obs_cs_lo); end
        n_chk++; if (obs_done_edge !== 78) begin n_fail++; $display("FAIL dreq_done_edge got=%0d want=78", obs_done_edge); end
        n_chk++; if (obs_rdata !== 16'h1357) begin n_fail++; $display("FAIL dreq_rdata got=%h want=1357", obs_rdata); end
    endtask

    task automatic test_start_ignored();
        run_txn(1'b0, REG_HDAT0, 16'hBEEF, 0, 20, -1, 300);
        n_chk++; if (obs_done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got=%0d want=1", obs_done_cnt); end
        n_chk++; if (obs_done_edge !== 68) begin n_fail++; $display("FAIL ignore_done_edge got=%0d want=68", obs_done_edge); end
        n_chk++; if (obs_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL ignore_rdata got=%h want=beef", obs_rdata); end
        // Issued in the cycle right after the done pulse.
        run_txn(1'b0, REG_HDAT1, 16'h1234, 0, -1, -1, 300);
        n_chk++; if (obs_busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b want=1", obs_busy0); end
        n_chk++; if (obs_done_edge !== 68) begin n_fail++; $display("FAIL b2b_done_edge got=%0d want=68", obs_done_edge); end
        n_chk++; if (obs_rdata !== 16'h1234) begin n_fail++; $display("FAIL b2b_rdata got=%h want=1234", obs_rdata); end
        n_chk++; if (obs_cmd[23:16] !== 8'h09) begin n_fail++; $display("FAIL b2b_addr got=%h want=09", obs_cmd[23:16]); end
    endtask

    task automatic test_reset_mid();
        run_txn(1'b0, REG_STATUS, 16'hFFFF, 0, -1, 30, 40);
        n_chk++; if (rs_cs !== 1'b1 || rs_sclk !== 1'b0 || rs_mosi !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus cs=%b sclk=%b mosi=%b want 1/0/0", rs_cs, rs_sclk, rs_mosi); end
        n_chk++; if (rs_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", rs_busy); end
        n_chk++; if (rs_rdata !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rdata got=%h want=0000", rs_rdata); end
        n_chk++; if (rs_done !== 1'b0 || obs_done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_done got=%b pulses=%0d want none", rs_done, obs_done_cnt); end
        run_txn(1'b0, REG_VOL, 16'h2020, 0, -1, -1, 300);
        n_chk++; if (obs_done_edge !== 68) begin n_fail++; $display("FAIL vol_done_edge got=%0d want=68", obs_done_edge); end
        n_chk++; if (obs_rdata !== 16'h2020) begin n_fail++; $display("FAIL vol_rdata got=%h want=2020", obs_rdata); end
        n_chk++; if (obs_cmd[23:16] !== 8'h0B) begin n_fail++; $display("FAIL vol_addr got=%h want=0b", obs_cmd[23:16]); end
    endtask

    task automatic test_slow_sclk();
        run_txn(1'b1, 4'hF, 16'hA5C3, 0, -1, -1, 400);
        n_chk++; if (obs_min_iv !== 4 || obs_max_iv !== 4) begin n_fail++; $display("FAIL slow_period got=%0d..%0d want=4", obs_min_iv, obs_max_iv); end
        n_chk++; if (obs_rises !== 32) begin n_fail++; $display("FAIL slow_rises got=%0d want=32", obs_rises); end
        n_chk++; if (obs_cmd[23:16] !== 8'h0F) begin n_fail++; $display("FAIL slow_addr got=%h want=0f", obs_cmd[23:16]); end
        n_chk++; if (obs_done_edge !== 132) begin n_fail++; $display("FAIL slow_done_edge got=%0d want=132", obs_done_edge); end
        n_chk++; if (obs_rdata !== 16'hA5C3) begin n_fail++; $display("FAIL slow_rdata got=%h want=a5c3", obs_rdata); end
        n_chk++; if (rdata_a !== 16'h2020) begin n_fail++; $display("FAIL slow_other_rdata got=%h want=2020", rdata_a); end
    endtask

    task automatic test_random();
        logic        s;
        logic [3:0]  a;
        logic [15:0] v;
        int          d, sh;
        logic [31:0] ecmd;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 4'($urandom);
            v = 16'($urandom);
            d = $urandom_range(0, 6);
            sh = s ? 2 : 1;
            ecmd = {8'h03, 4'h0, a, 16'h0000};
            run_txn(s, a, v, d, -1, -1, 400);
            n_chk++; if (obs_done_edge !== exp_latency(sh, d)) begin n_fail++; $display("FAIL rand%0d_done_edge got=%0d want=%0d", i, obs_done_edge, exp_latency(sh, d)); end
            n_chk++; if (obs_rdata !== v) begin n_fail++; $display("FAIL rand%0d_rdata got=%h want=%h", i, obs_rdata, v); end
            n_chk++; if (obs_cmd !== ecmd) begin n_fail++; $display("FAIL rand%0d_frame got=%h want=%h", i, obs_cmd, ecmd); end
            n_chk++; if (obs_rises !== 32 || obs_done_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_shape rises=%0d pulses=%0d want 32/1", i, obs_rises, obs_done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_read_status();
        test_dreq_gating();
        test_start_ignored();
        test_reset_mid();
        test_slow_sclk();
        test_random();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
